// File: rtl/axis_trace_recorder.sv
// Passive AXI-Stream tap: timestamps accepted beats and queues BEAT/END/DROP
// records in a first-word-fall-through FIFO for later readout.
module axis_trace_recorder #(
    parameter int DATA_WIDTH = 64,
    parameter int TS_WIDTH   = 32,
    parameter int DEPTH      = 16,
    parameter int REC_WIDTH  = 3 + TS_WIDTH + DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] mon_tdata,
    input  logic                  mon_tvalid,
    input  logic                  mon_tready,
    input  logic                  mon_tlast,
    input  logic                  ts_init,
    input  logic                  end_req,
    input  logic [15:0]           end_id,
    output logic                  end_pending,
    output logic [REC_WIDTH-1:0]  rec_data,
    output logic                  rec_valid,
    input  logic                  rec_ready,
    output logic                  overflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] TYPE_BEAT = 2'b00;
    localparam logic [1:0] TYPE_END  = 2'b01;
    localparam logic [1:0] TYPE_DROP = 2'b10;

    typedef enum logic {
        ST_CAPTURE   = 1'b0,
        ST_DROP_PEND = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [TS_WIDTH-1:0]   r_ts;
    logic [REC_WIDTH-1:0]  r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic [15:0]           r_drop_cnt;
    logic [15:0]           w_drop_cnt_next;
    logic                  r_end_pending;
    logic [15:0]           r_end_id;
    logic                  r_overflow;

    logic                  w_beat;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_wr;
    logic [1:0]            w_wr_type;
    logic                  w_wr_last;
    logic [DATA_WIDTH-1:0] w_wr_payload;
    logic [REC_WIDTH-1:0]  w_wr_data;
    logic                  w_end_clear;
    logic                  w_drop_event;
    logic [16:0]           w_drop_sum;
    logic [15:0]           w_drop_sat;

    assign w_beat  = enable & mon_tvalid & mon_tready;
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & rec_ready;

    // Drop count including the current beat, clamped to 16 bits.
    assign w_drop_sum = {1'b0, r_drop_cnt} + {16'd0, w_beat};
    assign w_drop_sat = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

    assign w_wr_data = {w_wr_type, r_ts, w_wr_last, w_wr_payload};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CAPTURE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Priority: pending DROP, then a captured beat, then a pending END.
    always_comb begin
        w_state_next    = r_state;
        w_wr            = 1'b0;
        w_wr_type       = TYPE_BEAT;
        w_wr_last       = 1'b0;
        w_wr_payload    = '0;
        w_drop_cnt_next = r_drop_cnt;
        w_end_clear     = 1'b0;
        w_drop_event    = 1'b0;
        if (!w_full) begin
            if (r_state == ST_DROP_PEND) begin
                w_wr            = 1'b1;
                w_wr_type       = TYPE_DROP;
                w_wr_payload    = DATA_WIDTH'(w_drop_sat);
                w_drop_cnt_next = '0;
                w_state_next    = ST_CAPTURE;
            end else if (w_beat) begin
                w_wr         = 1'b1;
                w_wr_type    = TYPE_BEAT;
                w_wr_last    = mon_tlast;
                w_wr_payload = mon_tdata;
            end else if (r_end_pending) begin
                w_wr         = 1'b1;
                w_wr_type    = TYPE_END;
                w_wr_last    = 1'b1;
                w_wr_payload = DATA_WIDTH'(r_end_id);
                w_end_clear  = 1'b1;
            end
        end else if (w_beat) begin
            w_drop_cnt_next = w_drop_sat;
            w_drop_event    = 1'b1;
            w_state_next    = ST_DROP_PEND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || ts_init) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_drop_cnt <= w_drop_cnt_next;
            if (w_drop_event) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // The first end_id is kept until its END record has been written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_end_pending <= 1'b0;
            r_end_id      <= '0;
        end else begin
            if (end_req && !r_end_pending) begin
                r_end_id <= end_id;
            end
            if (w_end_clear) begin
                r_end_pending <= 1'b0;
            end else if (end_req) begin
                r_end_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
        end
    end

    // Head entry is masked to zero while empty so stale contents never leak.
    assign rec_data    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign rec_valid   = ~w_empty;
    assign end_pending = r_end_pending;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_axis_trace_recorder.sv
// Self-checking bench for axis_trace_recorder: directed scenarios plus random
// traffic, compared every cycle against a queue-based record model.
module tb_axis_trace_recorder;

    localparam int DW    = 64;
    localparam int TW    = 32;
    localparam int DEPTH = 16;
    localparam int RW    = 3 + TW + DW;

    logic          clk;
    logic          rst;
    logic          enable;
    logic [DW-1:0] mon_tdata;
    logic          mon_tvalid;
    logic          mon_tready;
    logic          mon_tlast;
    logic          ts_init;
    logic          end_req;
    logic [15:0]   end_id;
    logic          end_pending;
    logic [RW-1:0] rec_data;
    logic          rec_valid;
    logic          rec_ready;
    logic          overflow;

    axis_trace_recorder #(
        .DATA_WIDTH(DW),
        .TS_WIDTH  (TW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mon_tdata  (mon_tdata),
        .mon_tvalid (mon_tvalid),
        .mon_tready (mon_tready),
        .mon_tlast  (mon_tlast),
        .ts_init    (ts_init),
        .end_req    (end_req),
        .end_id     (end_id),
        .end_pending(end_pending),
        .rec_data   (rec_data),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: the list of records the consumer should see.
    logic [RW-1:0] m_q[$];
    int            m_drop  = 0;
    bit            m_endp  = 0;
    logic [15:0]   m_eid   = '0;
    bit            m_ovf   = 0;
    logic [TW-1:0] m_ts    = '0;
    bit            m_known = 0;

    int n_pop_beat = 0;
    int n_pop_end  = 0;
    int n_pop_drop = 0;

    function automatic logic [RW-1:0] mkrec(logic [1:0] t, logic [TW-1:0] ts,
                                            logic l, logic [DW-1:0] p);
        return {t, ts, l, p};
    endfunction

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit            beat;
        bit            full;
        bit            pop;
        bit            push;
        bit            old_endp;
        int            sum;
        logic [RW-1:0] rec;
        beat = enable && mon_tvalid && mon_tready;
        if (rst) begin
            m_q.delete();
            m_drop  = 0;
            m_endp  = 0;
            m_ovf   = 0;
            m_ts    = '0;
            m_known = 1;
            return;
        end
        full     = (m_q.size() == DEPTH);
        pop      = (m_q.size() != 0) && rec_ready;
        push     = 0;
        old_endp = m_endp;
        rec      = '0;
        if (!full) begin
            if (m_drop != 0) begin
                sum = m_drop + (beat ? 1 : 0);
                if (sum > 65535) sum = 65535;
                rec    = mkrec(2'b10, m_ts, 1'b0, DW'(sum));
                push   = 1;
                m_drop = 0;
            end else if (beat) begin
                rec  = mkrec(2'b00, m_ts, mon_tlast, mon_tdata);
                push = 1;
            end else if (old_endp) begin
                rec    = mkrec(2'b01, m_ts, 1'b1, DW'(m_eid));
                push   = 1;
                m_endp = 0;
            end
        end else if (beat) begin
            if (m_drop < 65535) m_drop = m_drop + 1;
            m_ovf = 1;
        end
        if (end_req && !old_endp) begin
            m_endp = 1;
            m_eid  = end_id;
        end
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(rec);
        m_ts = ts_init ? '0 : m_ts + 1'b1;
    endtask

    // One clock cycle: compare outputs, advance the model, cross the edge.
    task automatic tick();
        if (m_known) begin
            check("rec_valid", 128'(rec_valid), 128'(m_q.size() != 0));
            if (m_q.size() != 0) check("rec_data", 128'(rec_data), 128'(m_q[0]));
            check("end_pending", 128'(end_pending), 128'(m_endp));
            check("overflow", 128'(overflow), 128'(m_ovf));
        end
        if (rec_valid === 1'b1 && rec_ready) begin
            case (rec_data[RW-1 -: 2])
                2'b00:   n_pop_beat++;
                2'b01:   n_pop_end++;
                default: n_pop_drop++;
            endcase
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mon_tvalid = 0;
        mon_tready = 0;
        mon_tlast  = 0;
        ts_init    = 0;
        end_req    = 0;
    endtask

    task automatic set_beat(logic [DW-1:0] d, logic l);
        mon_tvalid = 1;
        mon_tready = 1;
        mon_tdata  = d;
        mon_tlast  = l;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic drain(int n);
        idle();
        rec_ready = 1;
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    initial begin
        bit drop_seen;
        rst = 1; enable = 1; mon_tdata = '0; rec_ready = 0; end_id = '0;
        idle();
        do_reset();
        check("reset_rec_valid", 128'(rec_valid), 128'(0));
        check("reset_rec_data", 128'(rec_data), 128'(0));
        check("reset_end_pending", 128'(end_pending), 128'(0));
        check("reset_overflow", 128'(overflow), 128'(0));
        $display("reset: checked idle outputs");

        // Timestamp restart at cycle 5, beats at cycles 7 and 8.
        rec_ready = 0;
        for (int c = 0; c <= 8; c++) begin
            idle();
            if (c == 5) ts_init = 1;
            if (c == 7) set_beat(64'hA1, 1'b0);
            if (c == 8) set_beat(64'hA2, 1'b1);
            tick();
        end
        idle();
        check("ts_first_beat", 128'(rec_data), 128'(mkrec(2'b00, 32'd1, 1'b0, 64'hA1)));
        rec_ready = 1;
        tick();
        check("ts_second_beat", 128'(rec_data), 128'(mkrec(2'b00, 32'd2, 1'b1, 64'hA2)));
        drain(3);
        $display("timestamp: beats A1/A2 checked");

        // Overflow: 20 beats into a stalled FIFO, then release with beats continuing.
        do_reset();
        rec_ready = 0;
        for (int i = 0; i < 20; i++) begin
            set_beat(rnd_data(), 1'(i % 5 == 4));
            tick();
        end
        check("overflow_set", 128'(overflow), 128'(1));
        rec_ready = 1;
        drop_seen = 0;
        for (int i = 0; i < 30; i++) begin
            set_beat(rnd_data(), 1'($urandom_range(0, 3) == 0));
            tick();
            if (!drop_seen && rec_valid === 1'b1 && rec_data[RW-1 -: 2] == 2'b10) begin
                check("drop_count_min", 128'(rec_data[15:0] >= 16'd5), 128'(1));
                drop_seen = 1;
            end
        end
        check("drop_record_seen", 128'(drop_seen), 128'(1));
        drain(20);
        $display("overflow: drop record checked, overflow=%0b", overflow);

        // END ordering with an ignored second request.
        rec_ready = 0;
        idle();
        set_beat(64'h55, 1'b0);
        end_req = 1; end_id = 16'd3;
        tick();
        idle();
        end_req = 1; end_id = 16'd4;
        tick();
        idle();
        check("end_beat_payload", 128'(rec_data[DW-1:0]), 128'(64'h55));
        check("end_cleared", 128'(end_pending), 128'(0));
        rec_ready = 1;
        tick();
        check("end_record", 128'({rec_data[RW-1 -: 2], rec_data[DW], rec_data[DW-1:0]}),
              128'({2'b01, 1'b1, 64'd3}));
        drain(4);
        $display("end ordering: BEAT then END id 3");

        // Gating: handshakes with enable low are neither captured nor counted.
        do_reset();
        rec_ready = 0;
        n_pop_beat = 0; n_pop_drop = 0;
        enable = 0;
        for (int i = 0; i < 4; i++) begin
            set_beat(rnd_data(), 1'b0);
            tick();
        end
        enable = 1;
        set_beat(rnd_data(), 1'b1);
        tick();
        drain(6);
        check("gate_beats", 128'(n_pop_beat), 128'(1));
        check("gate_drops", 128'(n_pop_drop), 128'(0));
        check("gate_overflow", 128'(overflow), 128'(0));
        $display("gating: %0d beat(s) captured", n_pop_beat);

        // Backpressure: consumer ready toggling during a 10-beat burst.
        n_pop_beat = 0;
        for (int i = 0; i < 10; i++) begin
            set_beat(rnd_data(), 1'(i == 9));
            rec_ready = 1'(i % 2 == 0);
            tick();
        end
        drain(12);
        check("bp_beats", 128'(n_pop_beat), 128'(10));
        $display("backpressure: %0d beats delivered", n_pop_beat);

        // Reset mid-stream with records buffered and an END pending.
        rec_ready = 0;
        for (int i = 0; i < 6; i++) begin
            set_beat(rnd_data(), 1'b0);
            tick();
        end
        idle();
        end_req = 1; end_id = 16'd9;
        tick();
        idle();
        check("mid_pending", 128'(end_pending), 128'(1));
        rst = 1;
        tick();
        rst = 0;
        check("mid_rec_valid", 128'(rec_valid), 128'(0));
        check("mid_end_pending", 128'(end_pending), 128'(0));
        for (int i = 0; i < 3; i++) tick();
        set_beat(64'hBEEF, 1'b0);
        tick();
        idle();
        check("mid_ts", 128'(rec_data[DW+TW:DW+1]), 128'(3));
        drain(4);
        $display("reset mid-stream: cleared, ts restarted");

        // Random traffic with varying consumer pressure.
        for (int blk = 0; blk < 15; blk++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(10, 100);
            for (int i = 0; i < 200; i++) begin
                rst        = ($urandom_range(0, 599) == 0);
                enable     = ($urandom_range(0, 9) != 0);
                mon_tvalid = ($urandom_range(0, 3) != 0);
                mon_tready = ($urandom_range(0, 3) != 0);
                mon_tdata  = rnd_data();
                mon_tlast  = ($urandom_range(0, 7) == 0);
                ts_init    = ($urandom_range(0, 49) == 0);
                end_req    = ($urandom_range(0, 19) == 0);
                end_id     = 16'($urandom);
                rec_ready  = ($urandom_range(1, 100) <= rdy_pct);
                tick();
            end
            $display("random block %0d: ready %0d%%, beats %0d ends %0d drops %0d",
                     blk, rdy_pct, n_pop_beat, n_pop_end, n_pop_drop);
        end
        rst = 0;
        drain(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
